// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: sequential fetch, taken-branch redirects
// with a downstream flush window, BL link write and misaligned-target trap.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          FLUSH_SLOTS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic        br_link,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_target,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        flush,
    output logic        lr_we,
    output logic [31:0] lr_wdata,
    output logic        misalign_err,
    output logic [15:0] redirect_count
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_ERR   = 2'd2;

    localparam logic [3:0] C_FLUSH_INIT = 4'(FLUSH_SLOTS - 1);

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_pc;
    logic        r_if_valid;
    logic        r_flush;
    logic [3:0]  r_flush_cnt;
    logic        r_lr_we;
    logic [31:0] r_lr_wdata;
    logic        r_misalign;
    logic [15:0] r_redirect_count;

    logic w_not_err;
    logic w_take;
    logic w_aligned;

    assign w_not_err = (r_state != ST_ERR);
    assign w_take    = br_valid & br_taken & w_not_err;
    assign w_aligned = (br_target[1:0] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_RUN;
            r_pc             <= RESET_PC;
            r_if_pc          <= 32'h0;
            r_if_valid       <= 1'b0;
            r_flush          <= 1'b0;
            r_flush_cnt      <= 4'h0;
            r_lr_we          <= 1'b0;
            r_lr_wdata       <= 32'h0;
            r_misalign       <= 1'b0;
            r_redirect_count <= 16'h0;
        end else begin
            r_lr_we <= 1'b0;
            if (!w_not_err) begin
                // Trapped: fetch frozen until reset
                r_if_valid <= 1'b0;
                r_flush    <= 1'b0;
            end else if (w_take && w_aligned) begin
                r_pc        <= br_target;
                r_if_valid  <= 1'b0;
                r_flush     <= 1'b1;
                r_flush_cnt <= C_FLUSH_INIT;
                r_state     <= ST_FLUSH;
                if (r_redirect_count != 16'hFFFF)
                    r_redirect_count <= r_redirect_count + 16'h1;
                if (br_link) begin
                    r_lr_we    <= 1'b1;
                    r_lr_wdata <= br_pc + 32'h4;
                end
            end else if (w_take) begin
                r_misalign <= 1'b1;
                r_state    <= ST_ERR;
            end else if (!stall) begin
                r_pc       <= r_pc + 32'h4;
                r_if_pc    <= r_pc;
                r_if_valid <= 1'b1;
                if (r_state == ST_FLUSH) begin
                    if (r_flush_cnt == 4'h0) begin
                        r_flush <= 1'b0;
                        r_state <= ST_RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 4'h1;
                    end
                end
            end
        end
    end

    assign imem_addr      = r_pc;
    assign imem_req       = !stall && w_not_err;
    assign if_pc          = r_if_pc;
    assign if_valid       = r_if_valid;
    assign flush          = r_flush;
    assign lr_we          = r_lr_we;
    assign lr_wdata       = r_lr_wdata;
    assign misalign_err   = r_misalign;
    assign redirect_count = r_redirect_count;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expectations are queued as each step is
// driven and popped/compared one cycle-phase later against the outputs.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic        br_link;
    logic [31:0] br_pc;
    logic [31:0] br_target;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        flush;
    logic        lr_we;
    logic [31:0] lr_wdata;
    logic        misalign_err;
    logic [15:0] redirect_count;

    int n_checks = 0;
    int n_errors = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    pc_sequencer #(
        .RESET_PC    (32'h0000_0000),
        .FLUSH_SLOTS (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .br_valid       (br_valid),
        .br_taken       (br_taken),
        .br_link        (br_link),
        .br_pc          (br_pc),
        .br_target      (br_target),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .flush          (flush),
        .lr_we          (lr_we),
        .lr_wdata       (lr_wdata),
        .misalign_err   (misalign_err),
        .redirect_count (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic exp_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    function automatic logic [31:0] observe(input string tag);
        case (tag)
            "imem_addr": return imem_addr;
            "imem_req":  return {31'h0, imem_req};
            "if_pc":     return if_pc;
            "if_valid":  return {31'h0, if_valid};
            "flush":     return {31'h0, flush};
            "lr_we":     return {31'h0, lr_we};
            "lr_wdata":  return lr_wdata;
            "misalign":  return {31'h0, misalign_err};
            "count":     return {16'h0, redirect_count};
            default:     return 'x;
        endcase
    endfunction

    task automatic check_all(input string step);
        string       t;
        logic [31:0] e;
        logic [31:0] o;
        int          nstep;
        nstep = 0;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            o = observe(t);
            n_checks++;
            nstep++;
            assert (o === e) else begin
                n_errors++;
                $error("FAIL %s/%s: observed=%h expected=%h", step, t, o, e);
            end
        end
        $display("step %-14s checks=%0d total_errors=%0d imem_addr=%h if_pc=%h if_valid=%b flush=%b",
                 step, nstep, n_errors, imem_addr, if_pc, if_valid, flush);
    endtask

    // Advance one clock edge and compare just after it.
    task automatic cyc(input string step);
        @(posedge clk);
        #1;
        check_all(step);
    endtask

    task automatic br(input logic v, input logic t, input logic l,
                      input logic [31:0] bpc, input logic [31:0] tgt);
        br_valid  = v;
        br_taken  = t;
        br_link   = l;
        br_pc     = bpc;
        br_target = tgt;
    endtask

    task automatic exp_fetch(input logic [31:0] a, input logic [31:0] p,
                             input logic v, input logic f);
        exp_push("imem_addr", a);
        exp_push("if_pc", p);
        exp_push("if_valid", {31'h0, v});
        exp_push("flush", {31'h0, f});
    endtask

    task automatic exp_reset_state();
        exp_fetch(32'h0, 32'h0, 1'b0, 1'b0);
        exp_push("lr_we", 32'h0);
        exp_push("lr_wdata", 32'h0);
        exp_push("misalign", 32'h0);
        exp_push("count", 32'h0);
        exp_push("imem_req", 32'h1);
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        #3;
        exp_reset_state();
        check_all("reset");
        rst = 1'b0;

        // Free run from RESET_PC
        exp_fetch(32'h4, 32'h0, 1'b1, 1'b0);  cyc("seq1");
        exp_fetch(32'h8, 32'h4, 1'b1, 1'b0);  cyc("seq2");
        exp_fetch(32'hC, 32'h8, 1'b1, 1'b0);  cyc("seq3");

        // Taken B 0x100 -> 0x200
        br(1'b1, 1'b1, 1'b0, 32'h100, 32'h200);
        exp_push("imem_addr", 32'h200);
        exp_push("if_valid", 32'h0);
        exp_push("flush", 32'h1);
        exp_push("lr_we", 32'h0);
        exp_push("count", 32'h1);
        cyc("b_taken");
        br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_fetch(32'h204, 32'h200, 1'b1, 1'b1);  cyc("b_t+1");
        exp_fetch(32'h208, 32'h204, 1'b1, 1'b0);  cyc("b_t+2");

        // BL 0x40 -> 0x80
        br(1'b1, 1'b1, 1'b1, 32'h40, 32'h80);
        exp_push("imem_addr", 32'h80);
        exp_push("lr_we", 32'h1);
        exp_push("lr_wdata", 32'h44);
        exp_push("count", 32'h2);
        cyc("bl");
        br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_fetch(32'h84, 32'h80, 1'b1, 1'b1);
        exp_push("lr_we", 32'h0);
        exp_push("lr_wdata", 32'h44);
        cyc("bl_t+1");
        exp_fetch(32'h88, 32'h84, 1'b1, 1'b0);  cyc("bl_t+2");

        // Stall window with a redirect in the middle
        stall = 1'b1;
        #1;
        exp_push("imem_req", 32'h0);
        check_all("stall_req");
        exp_fetch(32'h88, 32'h84, 1'b1, 1'b0);  cyc("stall1");
        br(1'b1, 1'b1, 1'b0, 32'h2F8, 32'h300);
        exp_fetch(32'h300, 32'h84, 1'b0, 1'b1);
        exp_push("count", 32'h3);
        cyc("stall2_br");
        br(1'b1, 1'b0, 1'b1, 32'h4F8, 32'h500);
        exp_fetch(32'h300, 32'h84, 1'b0, 1'b1);
        exp_push("count", 32'h3);
        exp_push("lr_we", 32'h0);
        cyc("stall3_nt");
        br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        stall = 1'b0;
        exp_fetch(32'h304, 32'h300, 1'b1, 1'b1);  cyc("unstall1");
        exp_fetch(32'h308, 32'h304, 1'b1, 1'b0);  cyc("unstall2");

        // Address wrap at the top of the space
        br(1'b1, 1'b1, 1'b0, 32'h1000, 32'hFFFF_FFF8);
        exp_push("imem_addr", 32'hFFFF_FFF8);
        exp_push("count", 32'h4);
        cyc("to_top");
        br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_fetch(32'hFFFF_FFFC, 32'hFFFF_FFF8, 1'b1, 1'b1);  cyc("top+1");
        exp_fetch(32'h0,         32'hFFFF_FFFC, 1'b1, 1'b0);  cyc("wrap");

        // Back-to-back redirects extend the flush window
        br(1'b1, 1'b1, 1'b0, 32'h10, 32'h400);
        exp_fetch(32'h400, 32'hFFFF_FFFC, 1'b0, 1'b1);
        exp_push("count", 32'h5);
        cyc("rd_a");
        br(1'b1, 1'b1, 1'b0, 32'h404, 32'h600);
        exp_fetch(32'h600, 32'hFFFF_FFFC, 1'b0, 1'b1);
        exp_push("count", 32'h6);
        cyc("rd_b");
        br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_fetch(32'h604, 32'h600, 1'b1, 1'b1);  cyc("rd_b+1");
        exp_fetch(32'h608, 32'h604, 1'b1, 1'b0);  cyc("rd_b+2");

        // Misaligned target traps the sequencer
        br(1'b1, 1'b1, 1'b0, 32'h1F8, 32'h202);
        exp_push("misalign", 32'h1);
        exp_push("imem_addr", 32'h608);
        exp_push("imem_req", 32'h0);
        exp_push("count", 32'h6);
        cyc("misalign");
        br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        exp_push("imem_addr", 32'h608);
        exp_push("if_valid", 32'h0);
        exp_push("flush", 32'h0);
        exp_push("imem_req", 32'h0);
        cyc("err_hold");
        br(1'b1, 1'b1, 1'b1, 32'h6F8, 32'h700);
        exp_push("imem_addr", 32'h608);
        exp_push("count", 32'h6);
        exp_push("lr_we", 32'h0);
        exp_push("misalign", 32'h1);
        cyc("err_ignore");
        br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        exp_reset_state();
        check_all("async_rst");
        #2;
        rst = 1'b0;
        exp_fetch(32'h4, 32'h0, 1'b1, 1'b0);
        exp_push("imem_req", 32'h1);
        cyc("restart");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side program-counter sequencer and the consumer of resolved branch targets. It holds the architectural fetch PC, drives instruction-memory addresses, and advances by 4 each unstalled cycle. It accepts taken-branch redirects from execute (target already computed as branch PC + 8 + (offset<<2)), squashes wrong-path work downstream, and produces the link-register write for BL.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset; must be word aligned.
- FLUSH_SLOTS, 2, cycles `flush` is held after a redirect (1..15).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  downstream not accepting; freezes PC and fetch outputs.
- br_valid  in  1  execute presents a resolved branch this cycle.
- br_taken  in  1  branch taken (qualified by br_valid).
- br_link  in  1  branch is BL (qualified by br_valid & br_taken).
- br_pc  in  32  address of the branch instruction.
- br_target  in  32  resolved target address.
- imem_addr  out  32  instruction-memory address (equals pc_q).
- imem_req  out  1  fetch request.
- if_pc  out  32  address of instruction currently presented to decode.
- if_valid  out  1  if_pc / fetched instruction is valid.
- flush  out  1  kill decode/execute stage registers.
- lr_we  out  1  one-cycle link-register write strobe.
- lr_wdata  out  32  link value.
- misalign_err  out  1  sticky: redirect target not word aligned.
- redirect_count  out  16  taken-redirect counter, saturates at 16'hFFFF.

## Operation
- States: RUN, FLUSH, ERR. Reset: RUN, pc_q=RESET_PC, if_pc=0, if_valid=0, flush=0, lr_we=0, lr_wdata=0, misalign_err=0, redirect_count=0, flush counter=0.
- imem_addr = pc_q (combinational from register). imem_req = !stall & (state != ERR).
- Redirect condition: br_valid & br_taken & (state != ERR).
  - br_target[1:0]==0: pc_q<=br_target; if_valid<=0; flush<=1; counter<=FLUSH_SLOTS-1; state<=FLUSH; redirect_count += 1 unless saturated.
  - br_target[1:0]!=0: no redirect; misalign_err<=1; state<=ERR.
- A redirect takes priority over stall; it is accepted in RUN and FLUSH. A redirect in FLUSH reloads the counter.
- Link: accepted redirect with br_link -> lr_we<=1 for exactly one cycle, lr_wdata<=br_pc+4 (mod 2^32). lr_wdata holds its value otherwise.
- Not-taken branch (br_valid & !br_taken): no effect on any state.
- Sequential advance (no redirect, !stall, state != ERR): pc_q<=pc_q+4, wrapping 32'hFFFF_FFFC -> 32'h0; if_pc<=pc_q; if_valid<=1.
- Stall without redirect: pc_q, if_pc, if_valid, counter and flush all hold.
- FLUSH: on each unstalled cycle without redirect, counter==0 -> flush<=0, state<=RUN; otherwise counter decrements. The fetch stream continues during FLUSH; if_valid is independent of flush.
- ERR: pc_q frozen, imem_req=0, if_valid<=0, flush<=0. Only rst exits ERR. br_* inputs are ignored.

## Timing
- Synchronous instruction memory, 1-cycle read. The instruction for imem_addr at edge N pairs with if_pc after edge N+1.
- Redirect latency: br_valid sampled at edge T; imem_addr=br_target after edge T; if_valid=1 with if_pc=br_target after edge T+1 (if unstalled).
- flush is high for FLUSH_SLOTS unstalled cycles, starting after edge T.
- lr_we is high for the single cycle after edge T.
- All outputs are registered except imem_addr and imem_req.
- rst asserted mid-operation forces reset values immediately, regardless of clk.

## Test plan
- Reset release with RESET_PC=0, no branches -> imem_addr 0,4,8,12 on consecutive cycles; if_pc trails by one cycle; if_valid=1 from the second cycle.
- Taken B at edge T: br_pc=0x100, br_target=0x200 -> imem_addr=0x200 after T; flush high 2 cycles; if_pc=0x200 with if_valid after T+1; lr_we stays 0; redirect_count=1.
- BL with br_pc=0x40, br_target=0x80 -> lr_we single pulse, lr_wdata=0x44, pc redirected to 0x80.
- stall=1 for 3 cycles with a taken branch to 0x300 in the middle -> pc_q holds, then 0x300 on the redirect edge; flush persists until 2 unstalled cycles have passed; a not-taken branch with target 0x500 changes nothing.
- pc_q=0xFFFF_FFF8, free-running -> 0xFFFF_FFFC then 0x0000_0000; second redirect one cycle into FLUSH -> counter reloaded, flush extended.
- Taken branch with br_target=0x202 -> misalign_err=1, imem_req=0, pc frozen, later branches ignored; asynchronous rst mid-cycle -> all outputs at reset values and fetch restarts at RESET_PC.
